// File: rtl/axil_fifo_uart_tx.sv
// axil_fifo_uart_tx: pops {data, byte-enable} words from a show-ahead FIFO and
// serializes each enabled byte lane (lane 0 first, LSB first) as an 8N1/8N2 UART frame.
module axil_fifo_uart_tx #(
    parameter int DATA_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fif_dat,
    input  logic [STRB_WIDTH-1:0] fif_den,
    input  logic                  fif_val,
    output logic                  fif_pop,
    output logic                  uart_tx,
    output logic                  busy,
    output logic                  word_done
);
    localparam int LW = $clog2(STRB_WIDTH) + 1;
    localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, SEL, START, DATA, STOP} state_t;

    state_t                state, state_n;
    logic [LW-1:0]         lane, lane_n;
    logic [DATA_WIDTH-1:0] word, word_n;
    logic [STRB_WIDTH-1:0] strb, strb_n;
    logic [7:0]            shift, shift_n, lane_byte;
    logic [2:0]            bit_idx, bit_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic                  lane_en, tx_n;

    assign fif_pop = (state == IDLE) & fif_val;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            lane    <= '0;
            word    <= '0;
            strb    <= '0;
            shift   <= '0;
            bit_idx <= '0;
            cnt     <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_n;
            lane    <= lane_n;
            word    <= word_n;
            strb    <= strb_n;
            shift   <= shift_n;
            bit_idx <= bit_n;
            cnt     <= cnt_n;
            uart_tx <= tx_n;
        end
    end

    always_comb begin
        state_n   = state;
        lane_n    = lane;
        word_n    = word;
        strb_n    = strb;
        shift_n   = shift;
        bit_n     = bit_idx;
        cnt_n     = cnt;
        word_done = 1'b0;
        lane_byte = '0;
        lane_en   = 1'b0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (lane == LW'(i)) begin
                lane_byte = word[8*i +: 8];
                lane_en   = strb[i];
            end
        end
        unique case (state)
            IDLE: begin
                if (fif_val) begin
                    word_n  = fif_dat;
                    strb_n  = fif_den;
                    lane_n  = '0;
                    state_n = SEL;
                end
            end
            SEL: begin
                if (lane == LW'(STRB_WIDTH)) begin
                    word_done = 1'b1;
                    state_n   = IDLE;
                end else if (lane_en) begin
                    shift_n = lane_byte;
                    cnt_n   = '0;
                    state_n = START;
                end else begin
                    lane_n = lane + LW'(1);
                end
            end
            START: begin
                cnt_n = (cnt == BIT_END) ? '0 : cnt + CW'(1);
                if (cnt == BIT_END) begin
                    bit_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                cnt_n = (cnt == BIT_END) ? '0 : cnt + CW'(1);
                if (cnt == BIT_END) begin
                    shift_n = shift >> 1;
                    bit_n   = bit_idx + 3'd1;
                    state_n = (bit_idx == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                cnt_n = (cnt == STOP_END) ? '0 : cnt + CW'(1);
                if (cnt == STOP_END) begin
                    lane_n  = lane + LW'(1);
                    state_n = SEL;
                end
            end
            default: state_n = IDLE;
        endcase
        // line level is registered from the next state so each state's level starts on its first cycle
        tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? shift_n[0] : 1'b1;
    end
endmodule
